// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg
//   Shared types and constants for the PSRAM arbiter.
//   - arb_state_t : bus sequencer states (IDLE/SETUP/ACCESS/RECOVER)
//   - req_id_t    : requester identifiers (CHR/PRG/LDR, NONE = no grant)
//   - CNT_W       : width of the ACCESS/RECOVER cycle counter (covers ACCESS_CYCLES up to 15)
package psram_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_CHR  = 2'd0,
    REQ_PRG  = 2'd1,
    REQ_LDR  = 2'd2,
    REQ_NONE = 2'd3
  } req_id_t;

endpackage

// File: rtl/psram_arb_pick.sv
// psram_arb_pick
//   Combinational three-way grant selector for the PSRAM arbiter.
//   Build option ARB_ROUND_ROBIN_EN: CHR and PRG alternate on a tie (last served loses),
//   LDR always lowest; the pointer register resets to "CHR first". Without the macro the
//   priority is fixed CHR > PRG > LDR and no pointer register exists.
// Ports
//   clk_in, rst_in : memory clock / async active-high reset (pointer register only)
//   req[2:0]       : request levels, bit index = req_id_t (0 CHR, 1 PRG, 2 LDR)
//   last_id        : most recently granted requester
//   grant_id       : selected requester, REQ_NONE when no request is pending
module psram_arb_pick
  import psram_arb_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [2:0] req,
  input  req_id_t    last_id,
  output req_id_t    grant_id
);

`ifdef ARB_ROUND_ROBIN_EN
  logic prg_first_q;

  // Follows the last CHR/PRG grant; an LDR grant leaves the rotation untouched.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prg_first_q <= 1'b0;
    end else if (last_id == REQ_CHR) begin
      prg_first_q <= 1'b1;
    end else if (last_id == REQ_PRG) begin
      prg_first_q <= 1'b0;
    end
  end

  always_comb begin
    grant_id = REQ_NONE;
    if (req[0] && req[1]) begin
      grant_id = prg_first_q ? REQ_PRG : REQ_CHR;
    end else if (req[0]) begin
      grant_id = REQ_CHR;
    end else if (req[1]) begin
      grant_id = REQ_PRG;
    end else if (req[2]) begin
      grant_id = REQ_LDR;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk_in, rst_in, last_id};

  always_comb begin
    grant_id = REQ_NONE;
    if (req[0]) begin
      grant_id = REQ_CHR;
    end else if (req[1]) begin
      grant_id = REQ_PRG;
    end else if (req[2]) begin
      grant_id = REQ_LDR;
    end
  end
`endif

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares the asynchronous 16-bit PSRAM bus between three byte-wide req/ack requesters
//   (CHR, PRG, boot loader). One granted access runs SETUP -> ACCESS -> RECOVER; the
//   selected byte lane is steered and read data is returned on the requester's *_rd.
//   Build option ARB_ROUND_ROBIN_EN (see psram_arb_pick): CHR/PRG rotate priority.
// Parameters
//   ACCESS_CYCLES  : cycles with OE_n/WE_n asserted (1..15)
//   RECOVER_CYCLES : strobe-inactive cycles after each access (1..3)
// Ports
//   clk_in, rst_in                      : memory clock, async active-high reset
//   {chr,prg,ldr}_req/_we/_a/_wd        : request level, write flag, byte address, write data
//   {chr,prg,ldr}_ack/_rd               : one-cycle completion pulse, held read data
//   mem_a, mem_dq_out, mem_dq_in, mem_dq_oe : word address, write data, pad data, data drive
//   mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n : active-low PSRAM strobes
//   busy                                : high whenever the sequencer is not idle
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES  = 4,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        chr_req,
  input  logic        chr_we,
  input  logic [23:0] chr_a,
  input  logic [7:0]  chr_wd,
  output logic        chr_ack,
  output logic [7:0]  chr_rd,
  input  logic        prg_req,
  input  logic        prg_we,
  input  logic [23:0] prg_a,
  input  logic [7:0]  prg_wd,
  output logic        prg_ack,
  output logic [7:0]  prg_rd,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [23:0] ldr_a,
  input  logic [7:0]  ldr_wd,
  output logic        ldr_ack,
  output logic [7:0]  ldr_rd,
  output logic [22:0] mem_a,
  output logic [15:0] mem_dq_out,
  input  logic [15:0] mem_dq_in,
  output logic        mem_dq_oe,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic        busy
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_id_t          grant_q, pick_id;
  logic [23:0]      a_q;
  logic             we_q;
  logic [7:0]       wd_q;
  logic [2:0]       ack_q;
  logic [7:0]       chr_rd_q, prg_rd_q, ldr_rd_q;
  logic             access_last, recover_last, on_bus;
  logic [7:0]       lane_byte;

  assign access_last  = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));
  assign recover_last = (cnt_q == CNT_W'(RECOVER_CYCLES - 1));
  assign lane_byte    = a_q[0] ? mem_dq_in[15:8] : mem_dq_in[7:0];

  psram_arb_pick u_pick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .req      ({ldr_req, prg_req, chr_req}),
    .last_id  (grant_q),
    .grant_id (pick_id)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_id != REQ_NONE) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  if (access_last) state_d = ST_RECOVER;
      ST_RECOVER: if (recover_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counts cycles within ACCESS and RECOVER; restarts on every state change.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request fields are captured on the IDLE -> SETUP edge and held for the whole access.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_q <= REQ_NONE;
      a_q     <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
    end else if ((state_q == ST_IDLE) && (pick_id != REQ_NONE)) begin
      grant_q <= pick_id;
      case (pick_id)
        REQ_CHR: begin a_q <= chr_a; we_q <= chr_we; wd_q <= chr_wd; end
        REQ_PRG: begin a_q <= prg_a; we_q <= prg_we; wd_q <= prg_wd; end
        default: begin a_q <= ldr_a; we_q <= ldr_we; wd_q <= ldr_wd; end
      endcase
    end
  end

  // Read capture and ack both land on the edge leaving the last ACCESS cycle,
  // so *_rd is already valid during the ack pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ack_q    <= '0;
      chr_rd_q <= '0;
      prg_rd_q <= '0;
      ldr_rd_q <= '0;
    end else begin
      ack_q <= '0;
      if ((state_q == ST_ACCESS) && access_last) begin
        case (grant_q)
          REQ_CHR: begin
            ack_q[0] <= 1'b1;
            if (!we_q) chr_rd_q <= lane_byte;
          end
          REQ_PRG: begin
            ack_q[1] <= 1'b1;
            if (!we_q) prg_rd_q <= lane_byte;
          end
          REQ_LDR: begin
            ack_q[2] <= 1'b1;
            if (!we_q) ldr_rd_q <= lane_byte;
          end
          default: ;
        endcase
      end
    end
  end

  assign on_bus     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign mem_a      = a_q[23:1];
  assign mem_dq_out = {wd_q, wd_q};
  assign mem_dq_oe  = on_bus && we_q;
  assign mem_ce_n   = !on_bus;
  assign mem_oe_n   = !((state_q == ST_ACCESS) && !we_q);
  assign mem_we_n   = !((state_q == ST_ACCESS) && we_q);
  assign mem_lb_n   = !(on_bus && !a_q[0]);
  assign mem_ub_n   = !(on_bus && a_q[0]);
  assign busy       = (state_q != ST_IDLE);

  assign chr_ack = ack_q[0];
  assign prg_ack = ack_q[1];
  assign ldr_ack = ack_q[2];
  assign chr_rd  = chr_rd_q;
  assign prg_rd  = prg_rd_q;
  assign ldr_rd  = ldr_rd_q;

endmodule
